// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and response mux with unmapped/timeout error capture.
// Decode and data-phase passthrough are combinational (zero latency); a stalled slave is aborted after TIMEOUT_CYC waits.
module ahb_lite_decoder_mux #(
  parameter int                    N_SLV       = 2,
  parameter int                    AW          = 32,
  parameter int                    DW          = 32,
  parameter logic [N_SLV*AW-1:0]   SLV_BASE    = {32'hFFEE0000, 32'hFFDF0000},
  parameter logic [N_SLV*AW-1:0]   SLV_MASK    = {32'hFFFE0000, 32'hFFFF0000},
  parameter int                    TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       haddr,
  input  logic [1:0]          htrans,
  output logic [DW-1:0]       hrdata,
  output logic                hresp,
  output logic                hready,
  output logic [N_SLV-1:0]    hsel_s,
  input  logic [N_SLV-1:0]    readyout,
  input  logic [N_SLV-1:0]    resp,
  input  logic [N_SLV*DW-1:0] rdata,
  output logic                err_valid,
  output logic [AW-1:0]       err_addr,
  output logic                err_timeout,
  input  logic                err_clr,
  output logic                timeout_pulse
);

  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_SLV, ST_ERR1, ST_ERR2} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slv_q;
  logic [CW-1:0] wait_q;
  logic [AW-1:0] addr_q;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          accepted;
  logic          timeout_hit;
  logic          err_cap;

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((haddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
    hsel_s = hit ? (N_SLV'(1) << hit_idx) : '0;
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state_q)
      ST_SLV: begin
        hready = readyout[slv_q];
        hresp  = resp[slv_q];
        hrdata = rdata[int'(slv_q)*DW +: DW];
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign accepted    = hready && (htrans == 2'b10 || htrans == 2'b11);
  assign timeout_hit = (TIMEOUT_CYC > 0) && (state_q == ST_SLV) &&
                       !readyout[slv_q] && (wait_q == TO_MAX);
  assign err_cap     = (accepted && !hit) || timeout_hit;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERR1)
      state_d = ST_ERR2;
    else if (timeout_hit)
      state_d = ST_ERR1;
    else if (hready)
      state_d = accepted ? (hit ? ST_SLV : ST_ERR1) : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      slv_q         <= '0;
      wait_q        <= '0;
      addr_q        <= '0;
      err_valid     <= 1'b0;
      err_addr      <= '0;
      err_timeout   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeout_pulse <= timeout_hit;
      if (accepted)
        addr_q <= haddr;
      if (accepted && hit) begin
        slv_q  <= hit_idx;
        wait_q <= '0;
      end else if (state_q == ST_SLV && !readyout[slv_q] && wait_q != TO_MAX) begin
        wait_q <= wait_q + 1'b1;
      end
      // A timed-out transfer reports its own address-phase address, an unmapped one the address on the bus now.
      if (err_cap) begin
        err_valid   <= 1'b1;
        err_addr    <= timeout_hit ? addr_q : haddr;
        err_timeout <= timeout_hit;
      end else if (err_clr) begin
        err_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a transaction-level model.
module tb_ahb_lite_decoder_mux;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready;
  logic [1:0]  hsel_s;
  logic [1:0]  readyout;
  logic [1:0]  resp;
  logic [63:0] rdata;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_timeout;
  logic        err_clr;
  logic        timeout_pulse;

  always #5 clk = ~clk;

  ahb_lite_decoder_mux #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .haddr(haddr), .htrans(htrans),
    .hrdata(hrdata), .hresp(hresp), .hready(hready), .hsel_s(hsel_s),
    .readyout(readyout), .resp(resp), .rdata(rdata),
    .err_valid(err_valid), .err_addr(err_addr), .err_timeout(err_timeout),
    .err_clr(err_clr), .timeout_pulse(timeout_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 waiting on slave ks, 2 first error cycle, 3 second error cycle.
  bit          model_ok = 1'b0;
  int          ph = 0, ks = 0, waits = 0;
  logic [31:0] cur_addr = '0;
  logic        m_ev = 1'b0, m_et = 1'b0, m_tp = 1'b0;
  logic [31:0] m_ea = '0;
  logic [31:0] base [2] = '{32'hFFDF0000, 32'hFFEE0000};
  logic [31:0] mask [2] = '{32'hFFFF0000, 32'hFFFE0000};

  function automatic int slave_of(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & mask[i]) == base[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    int          s;
    logic [1:0]  esel;
    logic        ehr, ehresp, abort, acc, cap;
    logic [31:0] ehd;
    #1;
    s      = slave_of(haddr);
    esel   = (s < 0) ? 2'b00 : 2'(2'b01 << s);
    ehr    = 1'b1;
    ehresp = 1'b0;
    ehd    = '0;
    case (ph)
      1: begin ehr = readyout[ks]; ehresp = resp[ks]; ehd = rdata[ks*32 +: 32]; end
      2: begin ehr = 1'b0; ehresp = 1'b1; end
      3: ehresp = 1'b1;
      default: ;
    endcase
    abort = (ph == 1) && !readyout[ks] && (waits == TO);
    if (model_ok) begin
      chk("hsel_s", 32'(hsel_s), 32'(esel));
      chk("hready", 32'(hready), 32'(ehr));
      chk("hresp", 32'(hresp), 32'(ehresp));
      if (ph < 2) chk("hrdata", hrdata, ehd);
      chk("err_valid", 32'(err_valid), 32'(m_ev));
      chk("err_addr", err_addr, m_ea);
      chk("err_timeout", 32'(err_timeout), 32'(m_et));
      chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
    end
    acc = ehr && htrans[1];
    cap = 1'b0;
    if (!rst_n) begin
      ph = 0; waits = 0; cur_addr = '0;
      m_ev = 1'b0; m_ea = '0; m_et = 1'b0; m_tp = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_tp = abort;
      if (ph == 2) begin
        ph = 3;
      end else if (abort) begin
        ph = 2; cap = 1'b1; m_ea = cur_addr; m_et = 1'b1;
      end else if (ehr) begin
        if (!acc) begin
          ph = 0;
        end else begin
          cur_addr = haddr;
          if (s >= 0) begin
            ph = 1; ks = s; waits = 0;
          end else begin
            ph = 2; cap = 1'b1; m_ea = haddr; m_et = 1'b0;
          end
        end
      end else begin
        waits = (waits < TO) ? waits + 1 : TO;
      end
      if (cap) m_ev = 1'b1;
      else if (err_clr) m_ev = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    htrans   = 2'b00;
    haddr    = '0;
    readyout = 2'b11;
    resp     = 2'b00;
    err_clr  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rdata = '0;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_tpulse", 32'(timeout_pulse), 32'd0);
    tick();

    // Slave 0 read with two wait states.
    htrans = 2'b10; haddr = 32'hFFDF0004;
    #1; chk("rd_hsel", 32'(hsel_s), 32'h1);
    tick();
    htrans = 2'b00; readyout = 2'b10;
    for (int w = 0; w < 2; w++) begin
      #1; chk("rd_wait_hready", 32'(hready), 32'd0);
      tick();
    end
    readyout = 2'b11; rdata[31:0] = 32'h000000A5;
    #1;
    chk("rd_hready", 32'(hready), 32'd1);
    chk("rd_hrdata", hrdata, 32'h000000A5);
    chk("rd_hresp", 32'(hresp), 32'd0);
    tick();

    // Unmapped address.
    htrans = 2'b10; haddr = 32'h00001000;
    #1; chk("um_hsel", 32'(hsel_s), 32'h0);
    tick();
    htrans = 2'b00; haddr = '0;
    #1;
    chk("um_e1_hready", 32'(hready), 32'd0);
    chk("um_e1_hresp", 32'(hresp), 32'd1);
    chk("um_err_valid", 32'(err_valid), 32'd1);
    chk("um_err_addr", err_addr, 32'h00001000);
    chk("um_err_timeout", 32'(err_timeout), 32'd0);
    tick();
    #1;
    chk("um_e2_hready", 32'(hready), 32'd1);
    chk("um_e2_hresp", 32'(hresp), 32'd1);
    tick();

    // Slave 1 never answers: abort after TO wait cycles; late ready is ignored.
    htrans = 2'b10; haddr = 32'hFFEE0010;
    tick();
    htrans = 2'b00; haddr = '0; readyout = 2'b01;
    for (int w = 0; w <= TO; w++) begin
      #1;
      chk("to_wait_hready", 32'(hready), 32'd0);
      chk("to_wait_pulse", 32'(timeout_pulse), 32'd0);
      tick();
    end
    readyout = 2'b11;
    #1;
    chk("to_e1_hready", 32'(hready), 32'd0);
    chk("to_e1_hresp", 32'(hresp), 32'd1);
    chk("to_pulse", 32'(timeout_pulse), 32'd1);
    chk("to_err_timeout", 32'(err_timeout), 32'd1);
    chk("to_err_addr", err_addr, 32'hFFEE0010);
    tick();
    #1;
    chk("to_e2_hready", 32'(hready), 32'd1);
    chk("to_e2_hresp", 32'(hresp), 32'd1);
    chk("to_pulse_end", 32'(timeout_pulse), 32'd0);
    tick();

    // Back-to-back zero-wait transfers to different slaves.
    htrans = 2'b10; haddr = 32'hFFDF0000; rdata = {32'h22222222, 32'h11111111};
    #1; chk("b2b_hsel0", 32'(hsel_s), 32'h1);
    tick();
    htrans = 2'b10; haddr = 32'hFFEE0000;
    #1;
    chk("b2b_hsel1", 32'(hsel_s), 32'h2);
    chk("b2b_rdata0", hrdata, 32'h11111111);
    tick();
    htrans = 2'b00; haddr = '0;
    #1; chk("b2b_rdata1", hrdata, 32'h22222222);
    tick();

    // Capture beats a simultaneous clear.
    err_clr = 1'b1; htrans = 2'b10; haddr = 32'h00002000;
    tick();
    err_clr = 1'b0; htrans = 2'b00; haddr = '0;
    #1;
    chk("clr_race_valid", 32'(err_valid), 32'd1);
    chk("clr_race_addr", err_addr, 32'h00002000);
    tick();
    tick();

    // Reset during the first error cycle.
    htrans = 2'b10; haddr = 32'h00003000;
    tick();
    rst_n = 1'b0; htrans = 2'b00; haddr = '0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_e1_hready", 32'(hready), 32'd1);
    chk("rst_e1_hresp", 32'(hresp), 32'd0);
    chk("rst_e1_err_valid", 32'(err_valid), 32'd0);
    tick();

    for (int n = 0; n < 4000; n++) begin
      int lowp;
      int sel;
      lowp   = ((n / 400) % 2 == 1) ? 75 : 20;
      rst_n  = ($urandom_range(0, 299) != 0);
      htrans = 2'($urandom_range(0, 3));
      sel    = $urandom_range(0, 3);
      case (sel)
        0:       haddr = 32'hFFDF0000 | 32'($urandom_range(0, 32'hFFFF));
        1:       haddr = 32'hFFEE0000 | 32'($urandom_range(0, 32'h1FFFF));
        2:       haddr = $urandom;
        default: haddr = 32'h00001000 + 32'($urandom_range(0, 255));
      endcase
      for (int i = 0; i < 2; i++)
        readyout[i] = ($urandom_range(0, 99) >= lowp);
      resp    = 2'($urandom_range(0, 3));
      rdata   = {$urandom, $urandom};
      err_clr = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_decoder_mux.md
AHB_LITE_DECODER_MUX -- requirements
Module: ahb_lite_decoder_mux

Interface
REQ-001 SHALL have parameter N_SLV, default 2, meaning the number of AHB-Lite slaves (legal range 1..8).
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL have parameter DW, default 32, meaning the data width.
REQ-004 SHALL have parameter SLV_BASE, default {32'hFFEE0000, 32'hFFDF0000}, meaning a packed N_SLV*AW base-address array where slice i belongs to slave i.
REQ-005 SHALL have parameter SLV_MASK, default {32'hFFFE0000, 32'hFFFF0000}, meaning a packed N_SLV*AW decode-mask array.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of wait cycles before an abort; 0 disables the timeout.
REQ-007 SHALL have one clock and a synchronous active-low reset: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-008 SHALL have the master-side ports haddr  in  AW  and htrans  in  2, the master address phase.
REQ-009 SHALL have the master-side ports hrdata  out  DW, hresp  out  1 and hready  out  1; hready is also fed to every slave as HREADY_IN.
REQ-010 SHALL have the port hsel_s  out  N_SLV, the one-hot-or-zero address-phase slave selects.
REQ-011 SHALL have the slave-side ports readyout  in  N_SLV, resp  in  N_SLV and rdata  in  N_SLV*DW (slice i belongs to slave i).
REQ-012 SHALL have the error-capture ports err_valid  out  1 (sticky), err_addr  out  AW, err_timeout  out  1 (cause flag) and err_clr  in  1.
REQ-013 SHALL have the port timeout_pulse  out  1, a one-cycle pulse per timeout abort.

Function
REQ-014 SHALL decode combinationally: hsel_s[i]=1 iff (haddr & MASK[i]) == BASE[i]; on overlap only the lowest matching index SHALL be asserted.
REQ-015 SHALL treat a transfer as accepted when hready=1 and htrans[1]=1 (NONSEQ or SEQ); IDLE and BUSY transfers are never forwarded as errors.
REQ-016 SHALL register haddr into addr_q on every accepted transfer.
REQ-017 SHALL run a data-phase FSM with the states IDLE, SLV(k), ERR1 and ERR2.
REQ-018 SHALL make these FSM transitions whenever hready=1: an accepted mapped transfer goes to SLV(k); an accepted unmapped transfer goes to ERR1; no accepted transfer goes to IDLE.
REQ-019 SHALL drive hready=1, hresp=0 and hrdata=0 in IDLE.
REQ-020 SHALL pass readyout[k], resp[k] and rdata slice k straight through to hready, hresp and hrdata in SLV(k), with zero added latency.
REQ-021 SHALL drive hready=0 and hresp=1 in ERR1, then move unconditionally to ERR2.
REQ-022 SHALL drive hready=1 and hresp=1 in ERR2; the next state follows REQ-018.
REQ-023 SHALL, on entry to ERR1, set err_valid=1, load err_addr from addr_q, and set err_timeout to 1 for a timeout and 0 for an unmapped address.
REQ-024 SHALL keep a wait counter, cleared on entry to SLV, that increments each SLV cycle with readyout[k]=0 and saturates at TIMEOUT_CYC.
REQ-025 SHALL, when TIMEOUT_CYC>0 and the counter equals TIMEOUT_CYC while readyout[k]=0, go to ERR1, pulse timeout_pulse for 1 cycle and ignore slave k's late response.
REQ-026 SHALL NOT force hsel_s low after a timeout; the recovery of the timed-out slave is software's responsibility.
REQ-027 SHALL clear err_valid on err_clr=1 unless a new error is captured in the same cycle, in which case the capture wins.
REQ-028 SHALL update err_addr only on a capture; err_clr does not modify it.
REQ-029 SHALL handle back-to-back pipelined transfers across different slaves with no bubble cycle.

Reset
REQ-030 SHALL, on rst_n=0 at a clk edge, set: FSM=IDLE, wait counter=0, addr_q=0, hready=1, hresp=0, hrdata=0, err_valid=0, err_addr=0, err_timeout=0, timeout_pulse=0.
REQ-031 SHALL abandon any transfer or error in progress when reset is asserted, with the outputs per REQ-030 in the cycle after the reset edge.

Verification
REQ-032 Read 0xFFDF0004 with readyout[0] low for 2 cycles, then high with rdata0=0x000000A5 -> hready low 2 cycles, then hready=1, hrdata=0xA5, hresp=0.
REQ-033 NONSEQ to 0x00001000 -> hsel_s=00, then hready=0/hresp=1 followed by hready=1/hresp=1; err_valid=1, err_addr=0x00001000, err_timeout=0.
REQ-034 TIMEOUT_CYC=4 and readyout[1] held low on access 0xFFEE0010 -> timeout_pulse after 4 wait cycles, 2-cycle ERROR, err_timeout=1, err_addr=0xFFEE0010.
REQ-035 Zero-wait back-to-back NONSEQs to 0xFFDF0000 then 0xFFEE0000 -> hsel_s=01 then 10 in consecutive cycles; rdata0 and then rdata1 appear on consecutive cycles.
REQ-036 rst_n=0 during ERR1 -> in the next cycle hready=1, hresp=0, err_valid=0.
REQ-037 err_clr=1 in the same cycle as ERR1 entry for 0x00002000 -> err_valid stays 1 and err_addr=0x00002000.
